gated_clk_ctrl: RTL and testbench

- Generates the registered clock-enable that drives the downstream gated-clock primitive, which consumes it as its clken input.
- Converts host commands into exact enable windows: bursts of N enabled cycles, or continuous run until stopped.
- Enforces a guard gap between windows and reports completion, so peripherals such as LCD or SPI get precise clock-pulse counts.

---
 rtl/gated_clk_ctrl_if.sv | 26 ++
 rtl/gated_clk_ctrl.sv | 117 +++++++++++
 tb/tb_gated_clk_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/gated_clk_ctrl_if.sv
// Command/status bundle between a host and gated_clk_ctrl.
// The slave side is the controller; the master side is the host issuing commands.
interface gated_clk_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_cont;
  logic             stop_req;
  logic             clken;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pulse_cnt;

  modport master (
    output cmd_valid, cmd_len, cmd_cont, stop_req,
    input  cmd_ready, clken, busy, done, aborted, pulse_cnt
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_cont, stop_req,
    output cmd_ready, clken, busy, done, aborted, pulse_cnt
  );
endinterface

// File: rtl/gated_clk_ctrl.sv
// Registered clock-enable generator: turns host commands into exact clken windows
// (bursts or continuous runs) followed by a guard gap and a done pulse.
module gated_clk_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GUARD = 2
) (
  input logic            clkin,
  input logic            rst,
  gated_clk_ctrl_if.slave bus
);

  localparam int unsigned G_W = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GUARD} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] len_q, len_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic [G_W-1:0]   gcnt_q, gcnt_n;
  logic             cont_q, cont_n;
  logic             aborted_q, aborted_n;
  logic             done_q, done_n;
  logic             clken_q, busy_q, ready_q;
  logic             last_beat;

  always_comb begin
    state_n   = state;
    len_n     = len_q;
    cnt_n     = cnt_q;
    gcnt_n    = gcnt_q;
    cont_n    = cont_q;
    aborted_n = aborted_q;
    done_n    = 1'b0;
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    // cnt_q counts completed enabled cycles, so this edge closes beat cnt_q+1
    last_beat = !cont_q && ((cnt_q + CNT_W'(1)) == len_q);

    unique case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cnt_n     = '0;
          aborted_n = 1'b0;
          len_n     = bus.cmd_len;
          cont_n    = bus.cmd_cont;
          if (!bus.cmd_cont && (bus.cmd_len == '0)) begin
            if (GUARD == 0) begin
              state_n = S_IDLE;
              done_n  = 1'b1;
            end else begin
              state_n = S_GUARD;
              gcnt_n  = '0;
            end
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_n = cnt_inc;
        if (last_beat || bus.stop_req) begin
          if (!last_beat) aborted_n = 1'b1;
          if (GUARD == 0) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = S_GUARD;
            gcnt_n  = '0;
          end
        end
      end
      S_GUARD: begin
        if (gcnt_q == G_W'(GUARD - 1)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          gcnt_n = gcnt_q + G_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // All outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      gcnt_q    <= '0;
      cont_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_q    <= 1'b0;
      clken_q   <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      cnt_q     <= cnt_n;
      gcnt_q    <= gcnt_n;
      cont_q    <= cont_n;
      aborted_q <= aborted_n;
      done_q    <= done_n;
      clken_q   <= (state_n == S_RUN);
      busy_q    <= (state_n != S_IDLE);
      ready_q   <= (state_n == S_IDLE);
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.clken     = clken_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;
  assign bus.pulse_cnt = cnt_q;

endmodule

// File: tb/tb_gated_clk_ctrl.sv
// Bench for gated_clk_ctrl: a timeline model (accept edge, window length) predicts
// every output each cycle, with directed scenarios pinning key values literally.
module tb_gated_clk_ctrl;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GUARD = 2;
  localparam longint MAXC = (64'd1 << CNT_W) - 1;

  logic clkin;
  logic rst;

  gated_clk_ctrl_if #(.CNT_W(CNT_W)) bus ();

  gated_clk_ctrl #(.CNT_W(CNT_W), .GUARD(GUARD)) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Timeline model: window accepted at edge m_k, m_n enabled cycles (-1 while still open).
  int m_e = 0;
  int m_k = 0;
  int m_n = 0;
  int m_len = 0;
  bit m_cont = 0;
  bit m_act = 0;
  bit m_ab = 0;

  always @(posedge clkin or posedge rst) begin
    if (rst) begin
      m_act = 0;
      m_ab  = 0;
      m_n   = 0;
    end else begin
      bit rdy;
      rdy = !m_act || (m_n >= 0 && m_e >= m_k + m_n + int'(GUARD));
      m_e = m_e + 1;
      if (rdy && bus.cmd_valid) begin
        m_act  = 1;
        m_k    = m_e;
        m_ab   = 0;
        m_cont = bus.cmd_cont;
        m_len  = int'(bus.cmd_len);
        m_n    = (!bus.cmd_cont && bus.cmd_len == '0) ? 0 : -1;
      end else if (m_act && m_n < 0) begin
        if (!m_cont && (m_e - m_k) == m_len) begin
          m_n = m_len;
        end else if (bus.stop_req) begin
          m_n  = m_e - m_k;
          m_ab = 1;
        end
      end
    end
  end

  always @(negedge clkin) begin
    if (!rst) begin
      bit e_clk, e_busy, e_done;
      longint e_cnt;
      if (!m_act) begin
        e_clk = 0; e_busy = 0; e_done = 0; e_cnt = 0;
      end else begin
        e_clk  = (m_n < 0) || (m_e < m_k + m_n);
        e_busy = (m_n < 0) || (m_e < m_k + m_n + int'(GUARD));
        e_done = (m_n >= 0) && (m_e == m_k + m_n + int'(GUARD));
        e_cnt  = m_e - m_k;
        if (m_n >= 0 && e_cnt > m_n) e_cnt = m_n;
        if (e_cnt > MAXC) e_cnt = MAXC;
      end
      chk("clken",     bus.clken,     e_clk);
      chk("busy",      bus.busy,      e_busy);
      chk("cmd_ready", bus.cmd_ready, !e_busy);
      chk("done",      bus.done,      e_done);
      chk("aborted",   bus.aborted,   m_ab);
      chk("pulse_cnt", bus.pulse_cnt, e_cnt);
    end
  end

  task automatic issue(input int len, input bit cont);
    @(negedge clkin);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = CNT_W'(len);
    bus.cmd_cont  = cont;
    @(negedge clkin);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int hi, output int first, output int last, output int didx);
    hi = 0; first = -1; last = -1; didx = -1;
    for (int i = 0; i < 200; i++) begin
      if (bus.clken) begin
        hi++;
        if (first < 0) first = i;
        last = i;
      end
      if (bus.done) begin
        didx = i;
        break;
      end
      @(negedge clkin);
    end
    if (didx < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int hi, first, last, didx, low;
    bit seen, got;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_cont  = 1'b0;
    bus.stop_req  = 1'b0;
    repeat (3) @(negedge clkin);
    chk("rst_clken", bus.clken, 0);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_cnt",   bus.pulse_cnt, 0);
    chk("rst_busy",  bus.busy, 0);
    rst = 1'b0;
    repeat (2) @(negedge clkin);

    // 1: burst of 5
    issue(5, 0);
    wait_done(hi, first, last, didx);
    chk("t1_hi", hi, 5);
    chk("t1_latency", first, 0);
    chk("t1_done_gap", didx - last, GUARD + 1);
    chk("t1_cnt", bus.pulse_cnt, 5);
    chk("t1_abort", bus.aborted, 0);

    // 2: zero-length burst
    issue(0, 0);
    wait_done(hi, first, last, didx);
    chk("t2_hi", hi, 0);
    chk("t2_done_idx", didx, GUARD);
    chk("t2_cnt", bus.pulse_cnt, 0);
    chk("t2_ready", bus.cmd_ready, 1);

    // 3: continuous, stop after 10 enabled cycles
    issue(123, 1);
    repeat (9) @(negedge clkin);
    bus.stop_req = 1'b1;
    @(negedge clkin);
    bus.stop_req = 1'b0;
    chk("t3_clken_off", bus.clken, 0);
    wait_done(hi, first, last, didx);
    chk("t3_cnt", bus.pulse_cnt, 10);
    chk("t3_abort", bus.aborted, 1);

    // 4: burst of 8, stop level raised on the 8th cycle and held through guard/idle
    issue(8, 0);
    repeat (7) @(negedge clkin);
    bus.stop_req = 1'b1;
    wait_done(hi, first, last, didx);
    chk("t4_abort", bus.aborted, 0);
    chk("t4_cnt", bus.pulse_cnt, 8);
    repeat (3) @(negedge clkin);
    bus.stop_req = 1'b0;
    chk("t4_idle_cnt", bus.pulse_cnt, 8);
    chk("t4_idle_clken", bus.clken, 0);

    // 5: back-to-back, second command held during the first window
    @(negedge clkin);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = CNT_W'(4);
    bus.cmd_cont  = 1'b0;
    @(negedge clkin);
    bus.cmd_len = CNT_W'(3);
    low = 0; seen = 0; got = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) chk("t5_ready_on_done", bus.cmd_ready, 1);
      if (bus.clken && seen) begin
        got = 1;
        break;
      end
      if (!bus.clken) begin
        low++;
        seen = 1;
      end
      @(negedge clkin);
    end
    bus.cmd_valid = 1'b0;
    chk("t5_second_accepted", got, 1);
    chk("t5_gap", low, GUARD + 1);
    wait_done(hi, first, last, didx);
    chk("t5_hi", hi, 3);
    chk("t5_cnt", bus.pulse_cnt, 3);

    // 6: async reset on cycle 3 of a 6-cycle burst; commands during reset ignored
    issue(6, 0);
    repeat (2) @(negedge clkin);
    #2;
    rst = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = CNT_W'(4);
    #1;
    chk("t6_async_clken", bus.clken, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_ready", bus.cmd_ready, 1);
    chk("t6_async_cnt", bus.pulse_cnt, 0);
    repeat (3) @(negedge clkin);
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t6_no_done", bus.done, 0);
      chk("t6_no_clken", bus.clken, 0);
      @(negedge clkin);
    end
    chk("t6_ready", bus.cmd_ready, 1);
    chk("t6_cnt", bus.pulse_cnt, 0);

    repeat (3) @(negedge clkin);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
